// File: rtl/scan_sequencer.sv
// Two-level row/column scan sequencer: inner index nested in outer index, one step per unstalled cycle.
// Optional abort input and sticky aborted flag are built when SCAN_SEQ_ABORT_EN is defined.
module scan_sequencer #(
    parameter int N_IN  = 6,
    parameter int N_OUT = 6
) (
    input  logic             clock_i,
    input  logic             reset_ni,
`ifdef SCAN_SEQ_ABORT_EN
    input  logic             abort_i,
    output logic             aborted_o,
`endif
    input  logic             start_i,
    input  logic [N_IN-1:0]  in_limit_i,
    input  logic [N_OUT-1:0] out_limit_i,
    input  logic             stall_i,
    output logic             busy_o,
    output logic             step_valid_o,
    output logic [N_IN-1:0]  in_idx_o,
    output logic [N_OUT-1:0] out_idx_o,
    output logic             in_last_o,
    output logic             out_last_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    in_idx_q, in_idx_d;
    logic [N_OUT-1:0]   out_idx_q, out_idx_d;
    logic [N_IN-1:0]    lat_in_q, lat_in_d;
    logic [N_OUT-1:0]   lat_out_q, lat_out_d;
    logic               in_last, out_last;
`ifdef SCAN_SEQ_ABORT_EN
    logic               aborted_q, aborted_d;
`endif

    // Wrap is driven only by these compares, never by counter overflow.
    assign in_last  = (in_idx_q == lat_in_q);
    assign out_last = (out_idx_q == lat_out_q);

    always_comb begin
        state_d      = state_q;
        in_idx_d     = in_idx_q;
        out_idx_d    = out_idx_q;
        lat_in_d     = lat_in_q;
        lat_out_d    = lat_out_q;
        step_valid_o = 1'b0;
        done_o       = 1'b0;
`ifdef SCAN_SEQ_ABORT_EN
        aborted_d    = aborted_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    lat_in_d  = in_limit_i;
                    lat_out_d = out_limit_i;
                    in_idx_d  = '0;
                    out_idx_d = '0;
                    state_d   = ST_RUN;
`ifdef SCAN_SEQ_ABORT_EN
                    aborted_d = 1'b0;
`endif
                end
            end
            ST_RUN: begin
`ifdef SCAN_SEQ_ABORT_EN
                if (abort_i) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else
`endif
                if (!stall_i) begin
                    step_valid_o = 1'b1;
                    if (!in_last) begin
                        in_idx_d = in_idx_q + 1'b1;
                    end else if (!out_last) begin
                        in_idx_d  = '0;
                        out_idx_d = out_idx_q + 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            in_idx_q  <= '0;
            out_idx_q <= '0;
            lat_in_q  <= '0;
            lat_out_q <= '0;
`ifdef SCAN_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            lat_in_q  <= lat_in_d;
            lat_out_q <= lat_out_d;
`ifdef SCAN_SEQ_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign in_idx_o   = in_idx_q;
    assign out_idx_o  = out_idx_q;
    assign in_last_o  = in_last;
    assign out_last_o = out_last;
`ifdef SCAN_SEQ_ABORT_EN
    assign aborted_o  = aborted_q;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: vector table plus hand sequences for reset, long scans and abort.
module tb_scan_sequencer;
    localparam int N_IN  = 6;
    localparam int N_OUT = 6;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start;
    logic [N_IN-1:0]  in_limit;
    logic [N_OUT-1:0] out_limit;
    logic             stall;
    logic             busy, step_valid, in_last, out_last, done;
    logic [N_IN-1:0]  in_idx;
    logic [N_OUT-1:0] out_idx;
`ifdef SCAN_SEQ_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    always #5 clock = ~clock;

    scan_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clock_i      (clock),
        .reset_ni     (reset_n),
`ifdef SCAN_SEQ_ABORT_EN
        .abort_i      (abort),
        .aborted_o    (aborted),
`endif
        .start_i      (start),
        .in_limit_i   (in_limit),
        .out_limit_i  (out_limit),
        .stall_i      (stall),
        .busy_o       (busy),
        .step_valid_o (step_valid),
        .in_idx_o     (in_idx),
        .out_idx_o    (out_idx),
        .in_last_o    (in_last),
        .out_last_o   (out_last),
        .done_o       (done)
    );

    typedef struct {
        logic       start;
        int         il;
        int         ol;
        logic       stall;
        logic       busy;
        logic       sv;
        int         oi;
        int         ii;
        logic       chk_last;
        logic       ilast;
        logic       olast;
        logic       done;
    } vec_t;

    vec_t vq[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic st, input int il, input int ol, input logic stl,
                                input logic b, input logic sv, input int oi, input int ii,
                                input logic cl, input logic ilst, input logic olst, input logic dn);
        vec_t v;
        v.start = st; v.il = il; v.ol = ol; v.stall = stl;
        v.busy = b; v.sv = sv; v.oi = oi; v.ii = ii;
        v.chk_last = cl; v.ilast = ilst; v.olast = olst; v.done = dn;
        vq.push_back(v);
    endfunction

    // Reference scan: start, then follow every step against a nested-loop model.
    task automatic run_scan(input string name, input int il, input int ol, input int budget);
        int steps, ei, eo, errs, c, c_last, c_done;
        steps = 0; ei = 0; eo = 0; errs = 0; c_last = -1; c_done = -1;
        @(negedge clock);
        start = 1'b1; in_limit = N_IN'(il); out_limit = N_OUT'(ol); stall = 1'b0;
        for (c = 0; c < budget && c_done < 0; c++) begin
            @(negedge clock);
            start = 1'b0;
            #1;
            if (done) begin
                c_done = c;
            end else if (step_valid) begin
                if (int'(in_idx) != ei || int'(out_idx) != eo ||
                    in_last != (ei == il) || out_last != (eo == ol))
                    errs++;
                steps++;
                c_last = c;
                ei++;
                if (ei > il) begin
                    ei = 0;
                    eo++;
                end
            end
        end
        chk({name, "_steps"}, steps, (il + 1) * (ol + 1));
        chk({name, "_idx_errs"}, errs, 0);
        chk({name, "_done_seen"}, int'(c_done >= 0), 1);
        chk({name, "_done_lat"}, c_done - c_last, 1);
        @(negedge clock);
        #1;
        chk({name, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; in_limit = '0; out_limit = '0; stall = 1'b0;
`ifdef SCAN_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_sv", int'(step_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'({out_idx, in_idx}), 0);
`ifdef SCAN_SEQ_ABORT_EN
        chk("rst_aborted", int'(aborted), 0);
`endif
        @(negedge clock);
        reset_n = 1'b1;

        // Nominal 3x2 scan; limit inputs changed mid-scan must be ignored.
        add(1, 2, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 9, 9, 0,  1, 1, 0, 0,  1, 0, 0, 0);
        add(0, 9, 9, 0,  1, 1, 0, 1,  1, 0, 0, 0);
        add(0, 9, 9, 0,  1, 1, 0, 2,  1, 1, 0, 0);
        add(0, 9, 9, 0,  1, 1, 1, 0,  1, 0, 1, 0);
        add(0, 9, 9, 0,  1, 1, 1, 1,  1, 0, 1, 0);
        add(0, 9, 9, 0,  1, 1, 1, 2,  1, 1, 1, 0);
        add(0, 9, 9, 0,  1, 0, 1, 2,  1, 1, 1, 1);
        add(0, 9, 9, 0,  0, 0, 1, 2,  0, 0, 0, 0);
        // Stall in IDLE ignored, then three stall cycles at in_idx=1, stall in DONE ignored.
        add(0, 3, 0, 1,  0, 0, 1, 2,  0, 0, 0, 0);
        add(1, 3, 0, 0,  0, 0, 1, 2,  0, 0, 0, 0);
        add(0, 3, 0, 0,  1, 1, 0, 0,  1, 0, 1, 0);
        add(0, 3, 0, 1,  1, 0, 0, 1,  1, 0, 1, 0);
        add(0, 3, 0, 1,  1, 0, 0, 1,  1, 0, 1, 0);
        add(0, 3, 0, 1,  1, 0, 0, 1,  1, 0, 1, 0);
        add(0, 3, 0, 0,  1, 1, 0, 1,  1, 0, 1, 0);
        add(0, 3, 0, 0,  1, 1, 0, 2,  1, 0, 1, 0);
        add(0, 3, 0, 0,  1, 1, 0, 3,  1, 1, 1, 0);
        add(0, 3, 0, 1,  1, 0, 0, 3,  1, 1, 1, 1);
        add(0, 3, 0, 0,  0, 0, 0, 3,  0, 0, 0, 0);
        // Zero limits with start pulses in RUN and DONE ignored; start in IDLE accepted.
        add(1, 0, 0, 0,  0, 0, 0, 3,  0, 0, 0, 0);
        add(1, 5, 5, 0,  1, 1, 0, 0,  1, 1, 1, 0);
        add(1, 5, 5, 0,  1, 0, 0, 0,  1, 1, 1, 1);
        add(1, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 0, 0,  1, 1, 0, 0,  1, 0, 1, 0);
        add(0, 1, 0, 0,  1, 1, 0, 1,  1, 1, 1, 0);
        add(0, 1, 0, 0,  1, 0, 0, 1,  1, 1, 1, 1);
        add(0, 1, 0, 0,  0, 0, 0, 1,  0, 0, 0, 0);

        foreach (vq[k]) begin
            @(negedge clock);
            start = vq[k].start; in_limit = N_IN'(vq[k].il);
            out_limit = N_OUT'(vq[k].ol); stall = vq[k].stall;
            #1;
            chk($sformatf("v%0d_busy", k), int'(busy), int'(vq[k].busy));
            chk($sformatf("v%0d_sv", k), int'(step_valid), int'(vq[k].sv));
            chk($sformatf("v%0d_done", k), int'(done), int'(vq[k].done));
            chk($sformatf("v%0d_out_idx", k), int'(out_idx), vq[k].oi);
            chk($sformatf("v%0d_in_idx", k), int'(in_idx), vq[k].ii);
            if (vq[k].chk_last) begin
                chk($sformatf("v%0d_in_last", k), int'(in_last), int'(vq[k].ilast));
                chk($sformatf("v%0d_out_last", k), int'(out_last), int'(vq[k].olast));
            end
        end
        stall = 1'b0;

        // Reset after 5 of 12 steps abandons the scan without a done pulse.
        @(negedge clock);
        start = 1'b1; in_limit = 6'd3; out_limit = 6'd2;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        chk("midrst_pre_idx", int'({out_idx, in_idx}), int'({6'd1, 6'd1}));
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_idx", int'({out_idx, in_idx}), 0);
        chk("midrst_done", int'(done), 0);
        repeat (2) begin
            @(negedge clock);
            chk("midrst_hold_done", int'(done | step_valid), 0);
        end
        reset_n = 1'b1;
        run_scan("after_rst", 3, 2, 40);

        run_scan("nominal_model", 2, 1, 20);
        run_scan("all_ones", 63, 63, 4200);
`ifdef SCAN_SEQ_ABORT_EN
        chk("complete_not_aborted", int'(aborted), 0);

        // Abort ignored in IDLE.
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        #1 chk("abort_idle_busy", int'(busy), 0);

        // Abort (with stall) on step 10 of an 8x8 scan.
        start = 1'b1; in_limit = 6'd7; out_limit = 6'd7;
        for (int s = 1; s <= 9; s++) begin
            @(negedge clock);
            start = 1'b0;
            #1 chk($sformatf("abort_step%0d_sv", s), int'(step_valid), 1);
        end
        chk("abort_step9_idx", int'({out_idx, in_idx}), int'({6'd1, 6'd0}));
        @(negedge clock);
        abort = 1'b1; stall = 1'b1;
        #1 chk("abort_cycle_sv", int'(step_valid), 0);
        @(negedge clock);
        abort = 1'b0; stall = 1'b0;
        #1;
        chk("abort_done", int'(done), 1);
        chk("abort_busy", int'(busy), 1);
        chk("abort_sv_done", int'(step_valid), 0);
        chk("abort_flag_done", int'(aborted), 1);
        @(negedge clock);
        #1;
        chk("abort_idle_busy2", int'(busy), 0);
        chk("abort_done_once", int'(done), 0);
        chk("abort_flag_idle", int'(aborted), 1);
        start = 1'b1; in_limit = 6'd0; out_limit = 6'd0;
        @(negedge clock);
        start = 1'b0;
        #1 chk("abort_flag_cleared", int'(aborted), 0);
        repeat (3) @(negedge clock);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Two-level loop controller that sequences the team's counter-style index datapath for row/column scans. It latches inner and outer bounds on a start strobe and steps an inner index 0..in_limit nested inside an outer index 0..out_limit, one step per unstalled cycle. For each step it emits indices, a valid strobe and last-flags to the downstream datapath, then pulses done.

Parameters:
N_IN, 6, width of inner index and inner limit
N_OUT, 6, width of outer index and outer limit

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin scan; sampled only in IDLE
in_limit  input  N_IN  last inner index (inclusive); latched on accepted start
out_limit  input  N_OUT  last outer index (inclusive); latched on accepted start
stall  input  1  downstream back-pressure; freezes stepping
busy  output  1  high in any state other than IDLE
step_valid  output  1  current indices form a valid step this cycle
in_idx  output  N_IN  current inner index
out_idx  output  N_OUT  current outer index
in_last  output  1  in_idx == latched in_limit
out_last  output  1  out_idx == latched out_limit
done  output  1  single-cycle completion pulse

Behaviour:
- States: IDLE, RUN, DONE. Registers: state, in_idx, out_idx, lat_in, lat_out.
- Reset (reset low, asynchronous): state=IDLE; in_idx, out_idx, lat_in, lat_out = 0; busy=0, step_valid=0, done=0. Reset mid-scan abandons the scan with no done pulse.
- IDLE: start=1 at edge t latches limits, clears both indices, and moves to RUN at t+1. start=0 holds IDLE.
- RUN: step_valid = !stall (combinational). Stall holds the indices and the state. Each unstalled cycle is exactly one step:
  - in_last=0: in_idx+1.
  - in_last=1, out_last=0: in_idx=0, out_idx+1.
  - in_last=1, out_last=1: final step; next state DONE, indices hold.
- DONE: done=1 for exactly one cycle, step_valid=0, busy=1; next state IDLE unconditionally.
- Latency: first step_valid in the cycle after start is accepted, if not stalled. Total steps = (in_limit+1)*(out_limit+1). With no stalls, done asserts the cycle after the final step.
- Boundaries:
  - Both limits 0 gives exactly one step.
  - All-ones limits run 2^N_IN * 2^N_OUT steps. Index arithmetic is modulo width, but wrap occurs only via the in_last/out_last compare, never by overflow.
  - start while busy, including in DONE, is ignored; there is no queueing.
  - Limit inputs changing during a scan have no effect.
  - in_last and out_last are combinational compares against latched limits. They are meaningful only when busy; they are driven but don't-care in IDLE.
  - stall in IDLE or DONE is ignored.

Optional Feature:
Macro SCAN_SEQ_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit, sticky).
  - abort=1 in RUN at edge t goes to DONE at t+1, skipping remaining steps; step_valid is forced 0 during the abort cycle.
  - done still pulses once.
  - aborted=1 from DONE until the next accepted start or reset, which clears it to 0.
  - abort outside RUN is ignored. abort and stall together: abort wins.
- Not defined: ports abort and aborted are absent and the scan always runs to completion.

Test Plan:
- Reset mid-RUN: in_limit=3, out_limit=2, reset low after 5 steps -> busy=0, indices 0, no done pulse. A later start runs all 12 steps.
- Nominal: start with in_limit=2, out_limit=1, no stall -> 6 step_valid cycles, (out,in) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). in_last on steps 3 and 6, out_last on steps 4-6. done one cycle after step 6, busy low the cycle after done.
- Zero limits: in_limit=0, out_limit=0 -> one step (0,0) with in_last=out_last=1. done next cycle; busy high for exactly 2 cycles.
- Stall: in_limit=3, out_limit=0, stall high for 3 cycles while in_idx=1 -> step_valid=0 and in_idx=1 held. Total 4 valid steps, done delayed by 3 cycles.
- start ignored: pulse start with new limits during RUN and during DONE -> no scan restart, limits unchanged. start in IDLE the following cycle is accepted.
- Abort (SCAN_SEQ_ABORT_EN): in_limit=7, out_limit=7, abort at step 10 -> no step_valid after step 9. done next cycle, aborted=1 until next start.
